// File: rtl/obstacle_sched.sv
// obstacle_sched: paces obstacle placement requests from snake eats.
// LFSR candidates are offered to the placer until accepted or abandoned.
module obstacle_sched #(
  parameter int         EATS_PER_OBS = 4,
  parameter int         MAX_TRIES    = 8,
  parameter int         MAX_OBS      = 15,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       obstacleFlag,
  input  logic       s_reset,
  input  logic [7:0] curr_length,
  input  logic [3:0] obstacleCount,
  input  logic       place_ack,
  input  logic       place_err,
  output logic       place_req,
  output logic [3:0] randX,
  output logic [3:0] randY,
  output logic       busy,
  output logic       give_up
);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    REQ
  } state_t;

  localparam logic [3:0] EATS_M1 = 4'(EATS_PER_OBS - 1);
  localparam logic [3:0] MAX_T   = 4'(MAX_TRIES);
  localparam logic [4:0] MAXO    = 5'(MAX_OBS);

  state_t     state, state_n;
  logic [7:0] lfsr;
  logic [3:0] eat, eat_n;
  logic [3:0] tries, tries_n;
  logic [1:0] pending, pending_n;
  logic [3:0] rx_n, ry_n;
  logic       give_up_n;

  logic       active;
  logic       fb;
  logic [3:0] cand_x, cand_y;
  logic       cand_ok;
  logic       inc, dec;
  logic       cap;
  logic [8:0] gate_lhs, gate_rhs;
  logic       len_ok;
  logic [3:0] tries_inc;

  assign active    = obstacleFlag & ~s_reset;
  assign fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand_x    = lfsr[3:0];
  assign cand_y    = lfsr[7:4];
  assign cand_ok   = (cand_x >= 4'd1) && (cand_x <= 4'd14)
                  && (cand_y >= 4'd1) && (cand_y <= 4'd10);
  assign inc       = active & goodColl & (eat == EATS_M1);
  assign cap       = {1'b0, obstacleCount} >= MAXO;
  assign gate_lhs  = {4'd0, obstacleCount, 1'b0} + 9'd2;
  assign gate_rhs  = {1'b0, curr_length} + 9'd2;
  assign len_ok    = (curr_length < 8'd4) || (gate_lhs < gate_rhs);
  assign tries_inc = tries + 4'd1;

  assign place_req = (state == REQ);
  assign busy      = (state != IDLE);

  // Next-state, handshake bookkeeping and coordinate latch
  always_comb begin
    state_n   = state;
    tries_n   = tries;
    rx_n      = randX;
    ry_n      = randY;
    give_up_n = 1'b0;
    dec       = 1'b0;
    if (!active) begin
      state_n = IDLE;
      tries_n = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cap && len_ok && ((pending != 2'd0) || inc)) begin
            state_n = GEN;
            tries_n = 4'd0;
          end
        end
        GEN: begin
          if (cand_ok) begin
            rx_n    = cand_x;
            ry_n    = cand_y;
            state_n = REQ;
          end
        end
        REQ: begin
          if (place_ack) begin
            dec     = 1'b1;
            state_n = IDLE;
          end else if (place_err) begin
            tries_n = tries_inc;
            if (tries_inc == MAX_T) begin
              give_up_n = 1'b1;
              dec       = 1'b1;
              state_n   = IDLE;
            end else begin
              state_n = GEN;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Eat counter and saturating pending-request count
  always_comb begin
    eat_n     = eat;
    pending_n = pending;
    if (!active) begin
      eat_n     = 4'd0;
      pending_n = 2'd0;
    end else begin
      if (goodColl)
        eat_n = (eat == EATS_M1) ? 4'd0 : eat + 4'd1;
      if ((state == IDLE) && cap)
        pending_n = 2'd0;
      else if (inc && !dec && (pending != 2'd3))
        pending_n = pending + 2'd1;
      else if (dec && !inc && (pending != 2'd0))
        pending_n = pending - 2'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      eat     <= 4'd0;
      tries   <= 4'd0;
      pending <= 2'd0;
      randX   <= 4'd0;
      randY   <= 4'd0;
      give_up <= 1'b0;
    end else begin
      state   <= state_n;
      lfsr    <= {lfsr[6:0], fb};
      eat     <= eat_n;
      tries   <= tries_n;
      pending <= pending_n;
      randX   <= rx_n;
      randY   <= ry_n;
      give_up <= give_up_n;
    end
  end

endmodule

// File: tb/tb_obstacle_sched.sv
// tb_obstacle_sched: directed, table-driven and random checks
// of obstacle_sched against a behavioural model.
module tb_obstacle_sched;

  localparam int EATS = 4;
  localparam int MT   = 8;

  logic       clk = 1'b0;
  logic       nRst;
  logic       goodColl;
  logic       obstacleFlag;
  logic       s_reset;
  logic [7:0] curr_length;
  logic [3:0] obstacleCount;
  logic       place_ack;
  logic       place_err;
  logic       place_req;
  logic [3:0] randX;
  logic [3:0] randY;
  logic       busy;
  logic       give_up;

  obstacle_sched dut (
    .clk          (clk),
    .nRst         (nRst),
    .goodColl     (goodColl),
    .obstacleFlag (obstacleFlag),
    .s_reset      (s_reset),
    .curr_length  (curr_length),
    .obstacleCount(obstacleCount),
    .place_ack    (place_ack),
    .place_err    (place_err),
    .place_req    (place_req),
    .randX        (randX),
    .randY        (randY),
    .busy         (busy),
    .give_up      (give_up)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: 0 waiting, 1 searching, 2 offering
  int         m_mode;
  logic [7:0] m_lfsr;
  int         m_eat, m_pend, m_tries;
  logic [3:0] m_x, m_y;
  bit         m_give;

  typedef struct {
    logic [7:0] len;
    logic [3:0] cnt;
    logic       go;
  } gate_vec_t;

  gate_vec_t tbl[9];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int p;
    bit ate, gate, act;
    if (!nRst) begin
      m_mode = 0; m_lfsr = 8'hA5; m_eat = 0;
      m_pend = 0; m_tries = 0;
      m_x = 0; m_y = 0; m_give = 0;
      return;
    end
    act = obstacleFlag && !s_reset;
    m_give = 0;
    if (!act) begin
      m_mode = 0; m_pend = 0; m_eat = 0; m_tries = 0;
    end else begin
      ate = goodColl && (m_eat == EATS - 1);
      if (goodColl) m_eat = (m_eat + 1) % EATS;
      p = m_pend + int'(ate);
      gate = (curr_length < 4) ||
             (2 * (int'(obstacleCount) + 1) < int'(curr_length) + 2);
      case (m_mode)
        0: begin
          if (obstacleCount >= 15) p = 0;
          else if (p > 0 && gate) begin
            m_mode = 1; m_tries = 0;
          end
        end
        1: begin
          if (m_lfsr[3:0] inside {[1:14]} &&
              m_lfsr[7:4] inside {[1:10]}) begin
            m_x = m_lfsr[3:0];
            m_y = m_lfsr[7:4];
            m_mode = 2;
          end
        end
        default: begin
          if (place_ack) begin
            p--; m_mode = 0;
          end else if (place_err) begin
            m_tries++;
            if (m_tries == MT) begin
              m_give = 1; p--; m_mode = 0;
            end else m_mode = 1;
          end
        end
      endcase
      m_pend = (p > 3) ? 3 : p;
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nRst = 0; goodColl = 0; obstacleFlag = 0; s_reset = 0;
    curr_length = 8'd3; obstacleCount = 4'd0;
    place_ack = 0; place_err = 0;
    tick(); tick();
    nRst = 1;
  endtask

  task automatic eats(input int n);
    for (int i = 0; i < n; i++) begin
      goodColl = 1; tick();
      goodColl = 0; tick();
    end
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 300 && !place_req; i++) tick();
    check(name, 32'(place_req), 32'd1);
  endtask

  task automatic ack_one(input string name);
    wait_req(name);
    place_ack = 1; tick(); place_ack = 0;
  endtask

  int offers, gus;
  bit seen;
  logic [3:0] hx;

  initial begin
    tbl[0] = '{8'd3,   4'd0,  1'b1};
    tbl[1] = '{8'd3,   4'd14, 1'b1};
    tbl[2] = '{8'd10,  4'd5,  1'b0};
    tbl[3] = '{8'd11,  4'd5,  1'b1};
    tbl[4] = '{8'd4,   4'd1,  1'b1};
    tbl[5] = '{8'd4,   4'd2,  1'b0};
    tbl[6] = '{8'd255, 4'd14, 1'b1};
    tbl[7] = '{8'd0,   4'd15, 1'b0};
    tbl[8] = '{8'd5,   4'd2,  1'b1};

    do_reset();
    check("reset_outs",
          32'({place_req, busy, give_up, randX, randY}), 32'd0);
    check("reset_lfsr", 32'(dut.lfsr), 32'hA5);
    check("reset_pend", 32'(dut.pending), 32'd0);

    // basic request / accept
    obstacleFlag = 1;
    eats(3);
    goodColl = 1; tick(); goodColl = 0;
    check("busy_after_4th", 32'(busy), 32'd1);
    check("no_req_yet", 32'(place_req), 32'd0);
    wait_req("basic_req");
    check("x_range", 32'(randX >= 1 && randX <= 14), 32'd1);
    check("y_range", 32'(randY >= 1 && randY <= 10), 32'd1);
    place_ack = 1; tick(); place_ack = 0;
    check("basic_idle", 32'(busy), 32'd0);
    check("basic_pend", 32'(dut.pending), 32'd0);

    // every offer rejected
    do_reset(); obstacleFlag = 1;
    eats(4);
    offers = 0; gus = 0;
    for (int i = 0; i < 3000; i++) begin
      if (place_req) begin
        offers++; place_err = 1;
      end else place_err = 0;
      tick();
      if (give_up) begin gus++; break; end
    end
    place_err = 0;
    check("giveup_seen", 32'(gus), 32'd1);
    check("giveup_offers", 32'(offers), 32'(MT));
    check("giveup_busy", 32'(busy), 32'd0);
    check("giveup_pend", 32'(dut.pending), 32'd0);
    tick();
    check("giveup_pulse", 32'(give_up), 32'd0);

    // pending saturation while stalled
    do_reset(); obstacleFlag = 1;
    eats(16);
    check("sat_req", 32'(place_req), 32'd1);
    check("sat_pend", 32'(dut.pending), 32'd3);
    ack_one("sat_ack1");
    ack_one("sat_ack2");
    ack_one("sat_ack3");
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (place_req) seen = 1;
    end
    check("sat_no_more", 32'(seen), 32'd0);
    check("sat_busy", 32'(busy), 32'd0);

    // disable mid-request
    do_reset(); obstacleFlag = 1;
    eats(4);
    wait_req("dis_req");
    hx = m_x;
    obstacleFlag = 0; tick();
    check("dis_outs", 32'({place_req, busy}), 32'd0);
    check("dis_pend", 32'(dut.pending), 32'd0);
    check("dis_hold_x", 32'(randX), 32'(hx));
    obstacleFlag = 1;
    for (int i = 0; i < 20; i++) tick();
    check("dis_stay", 32'(busy), 32'd0);

    // length gate hold, then obstacle ceiling clears pending
    do_reset(); obstacleFlag = 1;
    curr_length = 8'd10; obstacleCount = 4'd5;
    eats(8);
    check("gate_hold", 32'(busy), 32'd0);
    check("gate_pend", 32'(dut.pending), 32'd2);
    obstacleCount = 4'd15; tick();
    check("cap_pend", 32'(dut.pending), 32'd0);
    curr_length = 8'd3;
    for (int i = 0; i < 10; i++) tick();
    check("cap_nobusy", 32'({place_req, busy}), 32'd0);

    // ack with err together, then reset mid-request
    do_reset(); obstacleFlag = 1;
    eats(4);
    wait_req("both_req1");
    place_err = 1; tick(); place_err = 0;
    wait_req("both_req2");
    place_ack = 1; place_err = 1; tick();
    place_ack = 0; place_err = 0;
    check("both_giveup", 32'(give_up), 32'd0);
    check("both_busy", 32'(busy), 32'd0);
    check("both_tries", 32'(dut.tries), 32'd1);
    eats(4);
    wait_req("rst_req");
    nRst = 0; place_ack = 1; tick();
    place_ack = 0; nRst = 1;
    check("rst_outs",
          32'({place_req, busy, give_up, randX, randY}), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'hA5);
    check("rst_pend", 32'(dut.pending), 32'd0);

    // length gate table
    foreach (tbl[k]) begin
      do_reset(); obstacleFlag = 1;
      curr_length = tbl[k].len;
      obstacleCount = tbl[k].cnt;
      eats(3);
      goodColl = 1; tick(); goodColl = 0;
      check($sformatf("gate_tbl%0d", k), 32'(busy), 32'(tbl[k].go));
    end

    // randomized run against the model
    do_reset();
    obstacleFlag = 1;
    for (int c = 0; c < 4000; c++) begin
      goodColl  = ($urandom_range(0, 9) < 3);
      place_ack = ($urandom_range(0, 9) < 2);
      place_err = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 49) == 0) obstacleFlag = ~obstacleFlag;
      if (!obstacleFlag && $urandom_range(0, 9) == 0)
        obstacleFlag = 1;
      s_reset = ($urandom_range(0, 99) == 0);
      nRst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 199) == 0)
        obstacleCount = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0)
        curr_length = 8'($urandom_range(0, 40));
      tick();
      check("rand_outs",
            32'({place_req, busy, give_up, randX, randY}),
            32'({m_mode == 2, m_mode != 0, m_give, m_x, m_y}));
      check("rand_pend", 32'(dut.pending), 32'(m_pend));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
